// File: rtl/gpu_pkg.sv
// Shared definitions for the vertex path.
// Holds the vertex table geometry, the coordinate slice offsets inside a
// vertex word, the shape select encodings and the reader FSM state type.
package gpu_pkg;

  localparam int NUM_VERTS = 12;  // vertex slots provided by the shape LUT
  localparam int VERT_W    = 48;  // {x, y, z}
  localparam int COORD_W   = 16;  // two's-complement fixed point
  localparam int IDX_W     = 4;   // 2**IDX_W must exceed NUM_VERTS

  localparam int X_LSB = 32;
  localparam int Y_LSB = 16;
  localparam int Z_LSB = 0;

  localparam logic [1:0] SHAPE_DEFAULT = 2'd0;  // 1..3 reserved

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } vsr_state_e;

endpackage

// File: rtl/vertex_stream_reader.sv
// Reader side of the shape vertex table.
// On start, latches the shape select (driven straight to the shape LUT) and
// the clamped vertex count, snapshots all LUT vertex words in one cycle, then
// streams the first N vertices one per beat over valid/ready.
//
// Ports:
//   clk, reset         clock (rising edge), async active-high reset
//   start              one-cycle request; samples shape_sel and vert_count
//   shape_sel          shape to fetch
//   vert_count         vertices to stream (clamped to NUM_VERTS)
//   abort              cancels a fetch/stream in progress
//   lut_shapeselect    select presented to the shape LUT
//   lut_vertices       flattened LUT words, v0 in the LSBs
//   out_valid/out_ready  beat handshake
//   out_x/out_y/out_z  coordinates of the current vertex
//   out_index          index of the current vertex
//   out_last           current beat is the final vertex
//   busy               block is not idle
//   done               one-cycle pulse on completion or abort
module vertex_stream_reader
  import gpu_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  shape_sel,
  input  logic [IDX_W-1:0]            vert_count,
  input  logic                        abort,
  output logic [1:0]                  lut_shapeselect,
  input  logic [NUM_VERTS*VERT_W-1:0] lut_vertices,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COORD_W-1:0]          out_x,
  output logic [COORD_W-1:0]          out_y,
  output logic [COORD_W-1:0]          out_z,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(NUM_VERTS);

  vsr_state_e                         state_q, state_d;
  logic [1:0]                         sel_q, sel_d;
  logic [IDX_W-1:0]                   cnt_q, cnt_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [NUM_VERTS-1:0][VERT_W-1:0]   snap_q, snap_d;

  logic              streaming;
  logic              last_beat;
  logic [VERT_W-1:0] cur_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign streaming = (state_q == ST_STREAM);
  // cnt_q is never 0 while streaming, so cnt_q-1 cannot wrap here.
  assign last_beat = (idx_q == cnt_q - IDX_W'(1));

  always_comb begin
    cur_word = '0;
    if (idx_q < MAX_CNT) cur_word = snap_q[idx_q];
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = shape_sel;
          cnt_d   = (vert_count > MAX_CNT) ? MAX_CNT : vert_count;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // LUT is combinational off sel_q, which settled the cycle before.
        snap_d = lut_vertices;
        idx_d  = '0;
        if (abort || cnt_q == '0) state_d = ST_DONE;
        else                      state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (out_ready) begin
          if (last_beat) state_d = ST_DONE;
          else           idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // All outputs decode from registers only; nothing depends on out_ready.
  assign lut_shapeselect = sel_q;
  assign out_valid       = streaming;
  assign out_x           = streaming ? cur_word[X_LSB +: COORD_W] : '0;
  assign out_y           = streaming ? cur_word[Y_LSB +: COORD_W] : '0;
  assign out_z           = streaming ? cur_word[Z_LSB +: COORD_W] : '0;
  assign out_index       = streaming ? idx_q : '0;
  assign out_last        = streaming && last_beat;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_vertex_stream_reader.sv
// Randomized self-checking bench for vertex_stream_reader, with a
// behavioural LUT and a beat-level expectation model.
module tb_vertex_stream_reader;
  import gpu_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset, start, abort, out_ready;
  logic [1:0]                  shape_sel, lut_shapeselect;
  logic [IDX_W-1:0]            vert_count, out_index;
  logic [NUM_VERTS*VERT_W-1:0] lut_vertices;
  logic                        out_valid, out_last, busy, done;
  logic [COORD_W-1:0]          out_x, out_y, out_z;

  int checks = 0;
  int failures = 0;

  logic [VERT_W-1:0] lut_mem [4][NUM_VERTS];
  logic              perturb = 1'b0;

  vertex_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .shape_sel(shape_sel),
    .vert_count(vert_count), .abort(abort), .lut_shapeselect(lut_shapeselect),
    .lut_vertices(lut_vertices), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_index(out_index),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural shape LUT; perturb flips every bit to model LUT changes.
  always_comb begin
    lut_vertices = '0;
    for (int i = 0; i < NUM_VERTS; i++)
      lut_vertices[i*VERT_W +: VERT_W] = lut_mem[lut_shapeselect][i] ^ {VERT_W{perturb}};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request. rmode: 0 ready high, 1 ready pattern 1,0,0, 2 random.
  // abort_beat: -1 none, -2 abort during fetch, k>=0 abort while beat k is
  // presented with ready low. stray: issue an extra start mid-stream.
  task automatic run(input logic [1:0] sel, input logic [3:0] vc, input int rmode,
                     input int abort_beat, input bit stray);
    logic [VERT_W-1:0] exp_v [NUM_VERTS];
    int n, k, done_c, c, b, exp_beats;
    bit rdy, ab, v_exp;
    n = (int'(vc) > NUM_VERTS) ? NUM_VERTS : int'(vc);
    for (int i = 0; i < NUM_VERTS; i++) exp_v[i] = lut_mem[sel][i];
    if (abort_beat == -2)                     exp_beats = 0;
    else if (abort_beat >= 0 && abort_beat < n) exp_beats = abort_beat;
    else                                      exp_beats = n;
    @(negedge clk);
    start = 1'b1; shape_sel = sel; vert_count = vc; abort = 1'b0; out_ready = 1'b0;
    k = 0; b = 0;
    done_c = (n == 0) ? 2 : -1;
    for (c = 1; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      if (c == 2) perturb = 1'b1;
      v_exp = (n > 0 && c >= 2 && done_c < 0);
      chk("valid", 64'(out_valid), 64'(v_exp));
      chk("done", 64'(done), 64'(c == done_c));
      chk("busy", 64'(busy), 64'd1);
      chk("lut_sel", 64'(lut_shapeselect), 64'(sel));
      if (c == done_c) break;
      if (v_exp) begin
        chk("index", 64'(out_index), 64'(k));
        chk("x", 64'(out_x), 64'(exp_v[k][47:32]));
        chk("y", 64'(out_y), 64'(exp_v[k][31:16]));
        chk("z", 64'(out_z), 64'(exp_v[k][15:0]));
        chk("last", 64'(out_last), 64'(k == n - 1));
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = (b % 3 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        b++;
        ab = (k == abort_beat);
        if (ab) begin rdy = 1'b0; abort = 1'b1; end
        out_ready = rdy;
        if (rdy) k++;
        if (ab || k == n) done_c = c + 1;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        if (abort_beat == -2 && c == 1) begin abort = 1'b1; done_c = 2; end
      end
      if (stray && c == 3) begin start = 1'b1; shape_sel = ~sel; vert_count = 4'd1; end
    end
    if (c >= 200) chk("timeout", 64'd1, 64'd0);
    chk("beats", 64'(k), 64'(exp_beats));
    start = 1'b0;
    perturb = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    shape_sel = '0; vert_count = '0;
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < NUM_VERTS; i++)
        lut_mem[s][i] = (s == 0) ? '0 : VERT_W'({$urandom(), $urandom()});
    lut_mem[0][0] = {16'h0000, 16'h0000, 16'h0330};
    lut_mem[0][1] = {16'hFFFF, 16'hFDBF, 16'hFCD0};
    lut_mem[0][2] = {16'h0001, 16'hFDBF, 16'hFCD0};
    lut_mem[0][3] = {16'h0000, 16'h0483, 16'hFCD0};

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sel", 64'(lut_shapeselect), 64'd0);
    chk("rst_data", 64'({out_x, out_y, out_z, out_index, out_last}), 64'd0);
    reset = 1'b0;

    // abort while idle does nothing
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'd0);
    chk("idle_abort_done", 64'(done), 64'd0);

    run(2'd0, 4'd4, 0, -1, 1'b0);
    run(2'd0, 4'd4, 1, -1, 1'b0);
    run(2'd0, 4'd0, 0, -1, 1'b0);
    run(2'd0, 4'd15, 0, -1, 1'b0);
    run(2'd0, 4'd4, 0, 1, 1'b0);
    run(2'd1, 4'd5, 2, -1, 1'b0);  // starts in the IDLE cycle right after DONE
    run(2'd2, 4'd3, 0, -2, 1'b0);
    run(2'd3, 4'd6, 1, -1, 1'b1);
    repeat (8)
      run(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2,
          int'($urandom_range(0, 14)) - 1, 1'($urandom_range(0, 1)));

    // reset during a stalled stream, with an ignored start before it
    @(negedge clk); start = 1'b1; shape_sel = 2'd3; vert_count = 4'd8; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; shape_sel = 2'd1; vert_count = 4'd2;
    @(negedge clk); start = 1'b0;
    chk("rs_valid", 64'(out_valid), 64'd1);
    chk("rs_index", 64'(out_index), 64'd0);
    chk("rs_sel", 64'(lut_shapeselect), 64'd3);
    chk("rs_x", 64'(out_x), 64'(lut_mem[3][0][47:32]));
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    chk("async_data", 64'({out_x, out_y, out_z, out_index, out_last, lut_shapeselect}), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
